// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset CPU with a single Avalon-style master port shared by fetch and data.
// Runs from RESET_VECTOR until a jump/branch to address 0 retires its delay slot, then halts.
module mips_cpu_bus #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t      state;
  logic [31:0] pc, npc, ir;
  logic [31:0] gpr [32];
  logic [1:0]  mem_off;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] rs_val, rt_val, simm, zimm, pc_plus4, ea;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign rs_val   = gpr[rs];
  assign rt_val   = gpr[rt];
  assign simm     = {{16{ir[15]}}, ir[15:0]};
  assign zimm     = {16'h0000, ir[15:0]};
  assign pc_plus4 = pc + 32'd4;
  assign ea       = rs_val + simm;

  assign register_v0 = gpr[2];

  logic        wb_en, taken, is_load, is_store;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val, target, st_data, load_val;
  logic [3:0]  mem_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wb_en    = 1'b0;
    wb_reg   = rd;
    wb_val   = '0;
    taken    = 1'b0;
    target   = pc_plus4 + {simm[29:0], 2'b00};
    is_load  = 1'b0;
    is_store = 1'b0;
    case (op)
      6'h00: begin
        wb_en = 1'b1;
        case (funct)
          6'h00: wb_val = rt_val << shamt;
          6'h02: wb_val = rt_val >> shamt;
          6'h03: wb_val = $signed(rt_val) >>> shamt;
          6'h04: wb_val = rt_val << rs_val[4:0];
          6'h06: wb_val = rt_val >> rs_val[4:0];
          6'h07: wb_val = $signed(rt_val) >>> rs_val[4:0];
          6'h08: begin wb_en = 1'b0; taken = 1'b1; target = rs_val; end
          6'h09: begin taken = 1'b1; target = rs_val; wb_val = pc + 32'd8; end
          6'h21: wb_val = rs_val + rt_val;
          6'h23: wb_val = rs_val - rt_val;
          6'h24: wb_val = rs_val & rt_val;
          6'h25: wb_val = rs_val | rt_val;
          6'h26: wb_val = rs_val ^ rt_val;
          6'h27: wb_val = ~(rs_val | rt_val);
          6'h2A: wb_val = {31'b0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: wb_val = {31'b0, rs_val < rt_val};
          default: wb_en = 1'b0;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) taken = rs_val[31];
        else if (rt == 5'd1) taken = !rs_val[31];
      end
      6'h02: begin taken = 1'b1; target = {pc_plus4[31:28], ir[25:0], 2'b00}; end
      6'h03: begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], ir[25:0], 2'b00};
        wb_en  = 1'b1;
        wb_reg = 5'd31;
        wb_val = pc + 32'd8;
      end
      6'h04: taken = (rs_val == rt_val);
      6'h05: taken = (rs_val != rt_val);
      6'h06: taken = rs_val[31] || (rs_val == '0);
      6'h07: taken = !rs_val[31] && (rs_val != '0);
      6'h09: begin wb_en = 1'b1; wb_reg = rt; wb_val = ea; end
      6'h0A: begin wb_en = 1'b1; wb_reg = rt; wb_val = {31'b0, $signed(rs_val) < $signed(simm)}; end
      6'h0B: begin wb_en = 1'b1; wb_reg = rt; wb_val = {31'b0, rs_val < simm}; end
      6'h0C: begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val & zimm; end
      6'h0D: begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val | zimm; end
      6'h0E: begin wb_en = 1'b1; wb_reg = rt; wb_val = rs_val ^ zimm; end
      6'h0F: begin wb_en = 1'b1; wb_reg = rt; wb_val = {ir[15:0], 16'h0000}; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_load = 1'b1;
      6'h28, 6'h29, 6'h2B: is_store = 1'b1;
      default: ;
    endcase
  end

  // op[1:0] distinguishes byte (00), half (01) and word (11) accesses for both loads and stores.
  always_comb begin
    case (op[1:0])
      2'b00:   begin mem_be = 4'b0001 << ea[1:0]; st_data = {4{rt_val[7:0]}}; end
      2'b01:   begin mem_be = ea[1] ? 4'b1100 : 4'b0011; st_data = {2{rt_val[15:0]}}; end
      default: begin mem_be = 4'b1111; st_data = rt_val; end
    endcase
  end

  always_comb begin
    ld_byte = readdata[7:0];
    case (mem_off)
      2'd1:    ld_byte = readdata[15:8];
      2'd2:    ld_byte = readdata[23:16];
      2'd3:    ld_byte = readdata[31:24];
      default: ld_byte = readdata[7:0];
    endcase
    ld_half = mem_off[1] ? readdata[31:16] : readdata[15:0];
    case (op)
      6'h20:   load_val = {{24{ld_byte[7]}}, ld_byte};
      6'h24:   load_val = {24'h0, ld_byte};
      6'h21:   load_val = {{16{ld_half[15]}}, ld_half};
      6'h25:   load_val = {16'h0, ld_half};
      default: load_val = readdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_VECTOR;
      npc        <= RESET_VECTOR + 32'd4;
      ir         <= '0;
      mem_off    <= '0;
      active     <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      writedata  <= '0;
      byteenable <= '0;
      for (int unsigned i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!read) begin
            read       <= 1'b1;
            address    <= pc;
            byteenable <= '1;
            active     <= 1'b1;
          end else if (!waitrequest) begin
            ir         <= readdata;
            read       <= 1'b0;
            byteenable <= '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (wb_en && wb_reg != 5'd0) gpr[wb_reg] <= wb_val;
          // pc advances to the delay slot; npc carries the resolved branch target.
          pc  <= npc;
          npc <= taken ? target : npc + 32'd4;
          if (is_load || is_store) begin
            state      <= MEM;
            address    <= {ea[31:2], 2'b00};
            byteenable <= mem_be;
            read       <= is_load;
            write      <= is_store;
            mem_off    <= ea[1:0];
            if (is_store) writedata <= st_data;
          end else if (npc == '0) begin
            state  <= HALT;
            active <= 1'b0;
          end else begin
            state      <= FETCH;
            read       <= 1'b1;
            address    <= npc;
            byteenable <= '1;
          end
        end
        MEM: begin
          if (!waitrequest) begin
            if (is_load && rt != 5'd0) gpr[rt] <= load_val;
            write     <= 1'b0;
            writedata <= '0;
            if (pc == '0) begin
              state      <= HALT;
              active     <= 1'b0;
              read       <= 1'b0;
              byteenable <= '0;
            end else begin
              state      <= FETCH;
              read       <= 1'b1;
              address    <= pc;
              byteenable <= '1;
            end
          end
        end
        default: begin
          read       <= 1'b0;
          write      <= 1'b0;
          byteenable <= '0;
          active     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Bench for mips_cpu_bus: small ROM/RAM slave with programmable stalls, a store scoreboard
// and a table of short programs whose final $v0 and store traffic are known.
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata;
  logic [3:0]  byteenable;

  mips_cpu_bus #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [16];
  logic [31:0] ram [16];
  int unsigned stall_cycles = 0;
  int unsigned wait_cnt = 0;

  assign waitrequest = (read || write) && (wait_cnt < stall_cycles);

  always_comb begin
    readdata = '0;
    if (read) readdata = (address[31:28] == 4'hB) ? rom[address[5:2]] : ram[address[5:2]];
  end

  always @(posedge clk) begin
    if (reset) wait_cnt <= 0;
    else if (read || write) wait_cnt <= waitrequest ? wait_cnt + 1 : 0;
    if (!reset && write && !waitrequest && address[31:28] != 4'hB)
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) ram[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;
  wr_t exp_wr[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        prev_hold = 1'b0;
  logic [69:0] prev_vec;
  wr_t         got_wr, want_wr;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (read || write) check32("rw_exclusive", {31'b0, read && write}, 32'd0);
      if (prev_hold)
        check32("stall_hold", {31'b0, prev_vec != {address, writedata, byteenable, read, write}}, 32'd0);
      prev_hold = (read || write) && waitrequest;
      prev_vec  = {address, writedata, byteenable, read, write};
      if (write && !waitrequest) begin
        got_wr = '{addr: address, data: writedata, be: byteenable};
        if (exp_wr.size() == 0) begin
          check32("wr_unexpected", address, 32'hFFFFFFFF);
        end else begin
          want_wr = exp_wr.pop_front();
          check32("wr_addr", got_wr.addr, want_wr.addr);
          check32("wr_data", got_wr.data, want_wr.data);
          check32("wr_be", {28'b0, got_wr.be}, {28'b0, want_wr.be});
        end
      end
    end
  end

  typedef struct {
    logic [0:7][31:0] prog;
    logic [31:0]      ram0;
    int unsigned      stall;
    bit               has_wr;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic [3:0]       wr_be;
    logic [31:0]      v0;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic load_prog(input logic [0:7][31:0] prog, input logic [31:0] ram0);
    for (int i = 0; i < 16; i++) begin
      rom[i] = (i < 8) ? prog[i] : 32'h0;
      ram[i] = 32'h0;
    end
    ram[0] = ram0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  cyc;
    bit  seen;
    reset = 1'b1;
    load_prog(v.prog, v.ram0);
    stall_cycles = v.stall;
    exp_wr.delete();
    if (v.has_wr) exp_wr.push_back('{addr: v.wr_addr, data: v.wr_data, be: v.wr_be});
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (active) seen = 1'b1;
      else if (seen) break;
      cyc++;
    end
    check32($sformatf("halt[%0d]", idx), {31'b0, seen && !active}, 32'd1);
    check32($sformatf("v0[%0d]", idx), register_v0, v.v0);
    check32($sformatf("wr_missing[%0d]", idx), exp_wr.size(), 32'd0);
    repeat (3) @(negedge clk);
    check32($sformatf("halted_bus[%0d]", idx), {29'b0, active, read, write}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{prog: {32'h24020005, 32'h2442FFF9, 32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h0, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'hFFFFFFFE};
    vecs[1]  = '{prog: {32'h3C030000, 32'h34630100, 32'h24041234, 32'hAC640000, 32'h8C620000, 32'h00000008, 32'h0, 32'h0},
                 ram0: 32'h0, stall: 0, has_wr: 1, wr_addr: 32'h100, wr_data: 32'h00001234, wr_be: 4'hF, v0: 32'h00001234};
    vecs[2]  = '{prog: {32'h34030100, 32'h80620001, 32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h00008000, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'hFFFFFF80};
    vecs[3]  = '{prog: {32'h34030100, 32'h90620001, 32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h00008000, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'h00000080};
    vecs[4]  = '{prog: {32'h34030100, 32'h340400AB, 32'hA0640003, 32'h8C620000, 32'h00000008, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h00008000, stall: 0, has_wr: 1, wr_addr: 32'h100, wr_data: 32'hABABABAB, wr_be: 4'h8, v0: 32'hAB008000};
    vecs[5]  = '{prog: {32'h34030100, 32'h2404FFFE, 32'hA4640002, 32'h84620002, 32'h00000008, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h00008000, stall: 0, has_wr: 1, wr_addr: 32'h100, wr_data: 32'hFFFEFFFE, wr_be: 4'hC, v0: 32'hFFFFFFFE};
    vecs[6]  = '{prog: {32'h10000002, 32'h24020001, 32'h24020009, 32'h24420001, 32'h00000008, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h0, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'h00000002};
    vecs[7]  = '{prog: {32'h24050003, 32'h2406FFFF, 32'h00A6102B, 32'h00C5382A, 32'h00471021, 32'h00021100, 32'h00000008, 32'h0},
                 ram0: 32'h0, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'h00000020};
    vecs[8]  = '{prog: {32'h24000005, 32'h00001021, 32'h24420007, 32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0},
                 ram0: 32'h0, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'h00000007};
    vecs[9]  = '{prog: {32'h0FF00004, 32'h0, 32'h00000008, 32'h0, 32'h03E01021, 32'h00000008, 32'h0, 32'h0},
                 ram0: 32'h0, stall: 0, has_wr: 0, wr_addr: 32'h0, wr_data: 32'h0, wr_be: 4'h0, v0: 32'hBFC00008};
    vecs[10] = vecs[1];
    vecs[10].stall = 3;

    // Reset state, first fetch, then reset landing in the middle of a stalled fetch.
    load_prog(vecs[0].prog, 32'h0);
    stall_cycles = 3;
    repeat (2) @(negedge clk);
    check32("reset_outputs", {28'b0, active, read, write, |byteenable}, 32'd0);
    check32("reset_v0", register_v0, 32'h0);
    @(negedge clk) reset = 1'b0;
    #1 check32("pre_edge_idle", {30'b0, read, write}, 32'd0);
    @(posedge clk) #1;
    check32("fetch_addr", address, 32'hBFC00000);
    check32("fetch_ctl", {27'b0, active, read, write, byteenable == 4'hF, waitrequest}, 32'b11011);
    reset = 1'b1;
    #1 check32("async_abort", {28'b0, active, read, write, |byteenable}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus.md
Name:
mips_cpu_bus

Overview:
- Multicycle MIPS-I subset CPU with a single Avalon-style memory-mapped master port used for both instruction fetch and data access.
- Top-level processor block: the memory or bus fabric connects directly to it.
- Runs from the reset vector until it jumps to address 0, then halts and exposes $v0 for result checking.

Parameters:
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high.
- active  out  1  high while executing; low in reset and after halt.
- register_v0  out  32  live value of GPR $2.
- address  out  32  byte address, always word-aligned (low 2 bits 0).
- write  out  1  write strobe.
- read  out  1  read strobe.
- waitrequest  in  1  slave stall; the current read/write is held while high.
- writedata  out  32  store data, little-endian lanes.
- byteenable  out  4  lane enables; bit0 = bits[7:0] = lowest byte address.
- readdata  in  32  read data, valid in the cycle read=1 and waitrequest=0.

Behaviour:
- Reset, asynchronous:
  - PC=RESET_VECTOR, all 32 GPRs=0, state=FETCH.
  - active=0, read=0, write=0, byteenable=0.
  - First FETCH starts on the first clk edge after reset falls.
- State machine: FETCH -> EXEC -> (MEM, loads and stores only) -> FETCH; HALT is terminal.
- FETCH:
  - read=1, address=PC, byteenable=4'b1111.
  - Held until waitrequest=0, then readdata is latched into IR.
- EXEC:
  - Decode, ALU, register write for ALU ops, branch/jump resolution.
  - No bus activity: read=0, write=0.
- MEM:
  - Address = (rs+sign-extended imm) with the low 2 bits cleared.
  - Held while waitrequest=1.
  - Loads write rt on the cycle the transfer completes.
- Bus rule: never assert read and write together; hold address, writedata and byteenable stable while waitrequest=1.
- Instructions:
  - ALU: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV.
  - Immediate: ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI.
  - Memory: LW, LB, LBU, LH, LHU, SW, SB, SH.
  - Control: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, J, JAL, JR, JALR.
- Arithmetic:
  - No overflow traps; all arithmetic wraps mod 2^32.
  - ANDI/ORI/XORI zero-extend the immediate; all other immediates sign-extend.
  - SLTIU compares the sign-extended immediate as unsigned.
  - Shift amount is shamt, or rs[4:0] for the variable shifts.
- Loads and stores, by byte offset o = ea[1:0]:
  - LW/SW: byteenable=1111.
  - LB/LBU/SB: byteenable = 1<<o.
  - LH/LHU/SH: byteenable = 0011 (o=0) or 1100 (o=2).
  - Store data is replicated into the selected lanes.
  - Load byte/half is extracted from the selected lanes, then sign- or zero-extended.
  - Misaligned LW/SW/LH/SH: low address bits are ignored (no exception).
- $zero: writes to $0 are discarded and $0 always reads 0.
- Delay slot:
  - Branches and jumps have one architectural delay slot; the slot instruction always executes.
  - Branch target = PC_of_branch + 4 + (simm<<2).
  - J/JAL target = {PC+4[31:28], idx, 2'b00}.
  - JAL/JALR link address = branch PC + 8 (JAL writes $31).
- Halt:
  - Triggered when a jump or branch resolves to target 32'h0.
  - The delay-slot instruction executes first; then the CPU enters HALT with active=0 and read=write=0, and stays there until reset.
- Undefined opcodes execute as NOP.
- Reset asserted mid-transaction aborts it immediately; outputs go to their reset values in the same cycle.
- register_v0 reflects register writes from the clock edge after the write.

Test Plan:
- Reset and fetch: assert reset, release -> first bus op is read=1, address=BFC00000, byteenable=1111; active=1; no write.
- Arithmetic and halt:
  - Program: ADDIU $2,$0,5; ADDIU $2,$2,-7; JR $0; NOP.
  - Expected: active falls after the NOP; register_v0=FFFFFFFE.
- Store/load round trip:
  - Program: LUI $3,0x0000; ORI $3,$3,0x100; ADDIU $4,$0,0x1234; SW $4,0($3); LW $2,0($3); halt.
  - Expected: write at address 00000100 with writedata=00001234, byteenable=1111; $v0=00001234.
- Byte ops:
  - Memory[0x100]=0x80 at lane 1 (address 0x101). Execute LB $2,1($3) -> $v0=FFFFFF80.
  - Execute LBU -> $v0=00000080.
  - Execute SB at offset 3 -> byteenable=1000.
- Waitrequest: hold waitrequest=1 for 3 cycles during a fetch and a SW -> address, writedata and strobes stay constant; the result matches the zero-wait run.
- Branch and delay slot:
  - Program: BEQ $0,$0,+2; ADDIU $2,$0,1 (slot); ADDIU $2,$0,9 (skipped); ADDIU $2,$2,1 (target); halt.
  - Expected: $v0=2.
